snes_pad_tx: RTL and testbench

Console-facing serial responder for the SNES controller port. It answers the console's latch/clock polling by driving the active-low data line on CONTDOUT with a 16-bit button word. Depending on mode, the word is the real pad's data passed through, a fully injected word, or the real pad merged with injected presses. It sits alongside the controller snooper/IGR block and runs on the master clock MCLKO.

---
 rtl/snes_pad_pkg.sv | 27 ++
 rtl/snes_pad_tx_if.sv | 24 ++
 rtl/snes_pad_sync.sv | 43 ++++
 rtl/snes_pad_tx.sv | 116 +++++++++++
 tb/tb_snes_pad_tx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES pad responder and its helpers.
package snes_pad_pkg;

    localparam int NBITS_DEFAULT = 16;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_REPLACE = 2'b01;
    localparam logic [1:0] MODE_MERGE   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_FILL
    } state_e;

    // Active-low line value for one bit: inj is the injected press (1 = pressed),
    // pad is the synchronized real pad line. Mode 11 falls back to passthrough.
    function automatic logic form_bit(input logic [1:0] mode, input logic inj, input logic pad);
        case (mode)
            MODE_REPLACE: return ~inj;
            MODE_MERGE:   return pad & ~inj;
            default:      return pad;
        endcase
    endfunction

endpackage

// File: rtl/snes_pad_tx_if.sv
// Console port pins plus injection controls and status of the pad responder.
interface snes_pad_tx_if #(
    parameter int NBITS = 16
);
    logic             CTRL_LATCH_i;
    logic             CTRL_CLK_i;
    logic             CTRL_SDATA_i;
    logic [1:0]       mode_i;
    logic [NBITS-1:0] pdata_i;
    logic             CTRL_SDATA_o;
    logic [4:0]       bit_idx_o;
    logic             busy_o;
    logic             frame_done_o;

    modport slave (
        input  CTRL_LATCH_i, CTRL_CLK_i, CTRL_SDATA_i, mode_i, pdata_i,
        output CTRL_SDATA_o, bit_idx_o, busy_o, frame_done_o
    );

    modport master (
        output CTRL_LATCH_i, CTRL_CLK_i, CTRL_SDATA_i, mode_i, pdata_i,
        input  CTRL_SDATA_o, bit_idx_o, busy_o, frame_done_o
    );
endinterface

// File: rtl/snes_pad_sync.sv
// Single-bit synchronizer with rise/fall detection on the synchronized copy.
// Edges are suppressed until the chain and the history flop hold real samples
// after reset, so a level already present at reset release is not an edge.
module snes_pad_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   arm_q, arm_d;

    // Next values: shift the pin in, remember last synced value, fill arm mask
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        prev_d = sync_q[STAGES-1];
        arm_d  = {arm_q[STAGES-1:0], 1'b1};
    end

    // Registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = arm_q[STAGES] &  q_o & ~prev_q;
    assign fall_o = arm_q[STAGES] & ~q_o &  prev_q;

endmodule

// File: rtl/snes_pad_tx.sv
// Console-facing SNES pad responder: answers latch/clock polling with a
// passthrough, injected or merged 16-bit button word on the active-low line.
module snes_pad_tx
    import snes_pad_pkg::*;
#(
    parameter int   NBITS       = NBITS_DEFAULT,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_LEVEL  = 1'b0
) (
    input logic          CLK_i,
    input logic          RST_i,
    snes_pad_tx_if.slave pad
);
    localparam logic [4:0] LAST = 5'(NBITS);

    logic latch_s, latch_rise, latch_fall;
    logic clk_s, clk_rise, clk_fall;
    logic sdata_s, sdata_rise, sdata_fall;

    snes_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_latch (
        .clk(CLK_i), .rst(RST_i), .d_i(pad.CTRL_LATCH_i),
        .q_o(latch_s), .rise_o(latch_rise), .fall_o(latch_fall)
    );
    snes_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk(CLK_i), .rst(RST_i), .d_i(pad.CTRL_CLK_i),
        .q_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall)
    );
    snes_pad_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdata (
        .clk(CLK_i), .rst(RST_i), .d_i(pad.CTRL_SDATA_i),
        .q_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{latch_s, clk_s, clk_fall, sdata_rise, sdata_fall};

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [NBITS-1:0] word_q, word_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NBITS-1:0] word_sh;

    // State register and all registered outputs
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            mode_q  <= MODE_PASS;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, capture, index advance; outputs derive from next-state values
    // so the line reflects a new bit in the same cycle the index moves.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (latch_rise) begin
            // Latch rise wins over any coincident clock rise, from any state
            state_d = ST_LOAD;
            idx_d   = '0;
            word_d  = pad.pdata_i;
            mode_d  = pad.mode_i;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_fall) begin
                        state_d = ST_SHIFT;
                        // Clock rise on the latch-fall cycle is the first shift
                        if (clk_rise) idx_d = 5'd1;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        idx_d = idx_q + 5'd1;
                        if (idx_d == LAST) begin
                            state_d = ST_FILL;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        word_sh = word_d >> idx_d;
        case (state_d)
            ST_IDLE: out_d = 1'b1;
            ST_FILL: out_d = FILL_LEVEL;
            default: out_d = form_bit(mode_d, word_sh[0], sdata_s);
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    end

    assign pad.CTRL_SDATA_o = out_q;
    assign pad.bit_idx_o    = idx_q;
    assign pad.busy_o       = busy_q;
    assign pad.frame_done_o = done_q;

endmodule

// File: tb/tb_snes_pad_tx.sv
// Directed + randomized polling of snes_pad_tx against a button-set model.
module tb_snes_pad_tx;
    localparam int NB   = 16;
    localparam int HALF = 16;   // console clock half period in master cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snes_pad_tx_if #(.NBITS(NB)) pad ();

    snes_pad_tx #(.NBITS(NB), .SYNC_STAGES(2), .FILL_LEVEL(1'b0)) dut (
        .CLK_i(clk),
        .RST_i(rst),
        .pad  (pad.slave)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Count cycles with frame_done high (a one-cycle pulse adds exactly one)
    always @(posedge clk) if (pad.frame_done_o === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected console line at bit k: pressed set is pad, injected, or their union
    function automatic logic exp_line(input logic [1:0] m, input logic [15:0] pd,
                                      input logic [15:0] pw, input int k);
        logic [15:0] pressed;
        logic [15:0] t;
        if (k >= NB) return 1'b0;
        case (m)
            2'b01:   pressed = pd;
            2'b10:   pressed = pd | pw;
            default: pressed = pw;
        endcase
        t = pressed >> k;
        return ~t[0];
    endfunction

    function automatic logic pad_line(input logic [15:0] pw, input int k);
        logic [15:0] t;
        if (k >= NB) return 1'b1;
        t = pw >> k;
        return ~t[0];
    endfunction

    // One console poll: latch pulse then nclk clock pulses, checking every bit
    task automatic poll(input logic [1:0] m, input logic [15:0] pd, input logic [15:0] pw,
                        input int nclk, input string tag);
        int base;
        int ei;
        base = done_cnt;
        pad.mode_i       = m;
        pad.pdata_i      = pd;
        pad.CTRL_SDATA_i = pad_line(pw, 0);
        pad.CTRL_LATCH_i = 1'b1;
        tick(4);
        chk({tag, "_latch_busy"}, 32'(pad.busy_o), 32'd1);
        chk({tag, "_latch_idx"}, 32'(pad.bit_idx_o), 32'd0);
        chk({tag, "_latch_bit0"}, 32'(pad.CTRL_SDATA_o), 32'(exp_line(m, pd, pw, 0)));
        // Mid-frame changes must not affect the captured word/mode
        pad.pdata_i = ~pd;
        pad.mode_i  = m ^ 2'b01;
        tick(2 * HALF - 4);
        pad.CTRL_LATCH_i = 1'b0;
        tick(HALF);
        for (int k = 0; k < nclk; k++) begin
            pad.CTRL_CLK_i = 1'b0;
            tick(HALF);
            ei = (k < NB) ? k : NB;
            chk({tag, "_data"}, 32'(pad.CTRL_SDATA_o), 32'(exp_line(m, pd, pw, k)));
            chk({tag, "_idx"}, 32'(pad.bit_idx_o), 32'(ei));
            if (k == NB - 1) chk({tag, "_done_early"}, 32'(done_cnt - base), 32'd0);
            if (k == NB) chk({tag, "_done_after16"}, 32'(done_cnt - base), 32'd1);
            pad.CTRL_CLK_i = 1'b1;
            tick(4);
            pad.CTRL_SDATA_i = pad_line(pw, k + 1);
            tick(HALF - 4);
        end
        if (nclk > NB) begin
            chk({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
            chk({tag, "_fill_busy"}, 32'(pad.busy_o), 32'd0);
            chk({tag, "_fill_idx"}, 32'(pad.bit_idx_o), 32'(NB));
            chk({tag, "_fill_line"}, 32'(pad.CTRL_SDATA_o), 32'd0);
        end else begin
            chk({tag, "_no_done"}, 32'(done_cnt - base), 32'd0);
        end
        pad.CTRL_SDATA_i = 1'b1;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rm;
        int          base;
        int          changed;

        pad.CTRL_LATCH_i = 1'b0;
        pad.CTRL_CLK_i   = 1'b1;
        pad.CTRL_SDATA_i = 1'b1;
        pad.mode_i       = 2'b00;
        pad.pdata_i      = '0;

        // Reset and idle
        rst = 1'b1;
        tick(4);
        chk("rst_line", 32'(pad.CTRL_SDATA_o), 32'd1);
        chk("rst_idx", 32'(pad.bit_idx_o), 32'd0);
        chk("rst_busy", 32'(pad.busy_o), 32'd0);
        chk("rst_done", 32'(pad.frame_done_o), 32'd0);
        rst = 1'b0;
        base = done_cnt;
        changed = 0;
        for (int i = 0; i < 10000; i++) begin
            tick(1);
            if (pad.CTRL_SDATA_o !== 1'b1 || pad.bit_idx_o !== 5'd0 || pad.busy_o !== 1'b0)
                changed++;
        end
        chk("idle_stable", 32'(changed), 32'd0);
        chk("idle_no_done", 32'(done_cnt - base), 32'd0);

        // Directed modes
        poll(2'b01, 16'h8001, 16'h0000, 20, "replace");
        poll(2'b10, 16'h0010, 16'h0008, 18, "merge");
        ra = 16'($urandom);
        poll(2'b00, 16'hFFFF, ra, 18, "pass");

        // Restart after 7 clocks, then full poll with a new word
        poll(2'b01, 16'h00F0, 16'h0000, 7, "abort");
        chk("abort_idx", 32'(pad.bit_idx_o), 32'd7);
        poll(2'b01, 16'h1234, 16'h0000, 18, "restart");

        // Latch rise coincident with clock rise while shifting
        poll(2'b01, 16'h5555, 16'h0000, 5, "pre_coll");
        pad.CTRL_CLK_i = 1'b0;
        tick(HALF);
        pad.pdata_i = 16'h0002;
        pad.mode_i  = 2'b01;
        pad.CTRL_LATCH_i = 1'b1;
        pad.CTRL_CLK_i   = 1'b1;
        tick(6);
        chk("coll_rise_idx", 32'(pad.bit_idx_o), 32'd0);
        chk("coll_rise_busy", 32'(pad.busy_o), 32'd1);
        // Clock toggling during latch is ignored; fall + rise together shifts once
        pad.CTRL_CLK_i = 1'b0;
        tick(HALF);
        chk("coll_load_idx", 32'(pad.bit_idx_o), 32'd0);
        pad.CTRL_LATCH_i = 1'b0;
        pad.CTRL_CLK_i   = 1'b1;
        tick(6);
        chk("coll_fall_idx", 32'(pad.bit_idx_o), 32'd1);
        chk("coll_fall_line", 32'(pad.CTRL_SDATA_o), 32'd0);

        // Reset at index 9
        rb = 16'($urandom);
        poll(2'b01, rb, 16'h0000, 9, "pre_rst");
        chk("pre_rst_idx", 32'(pad.bit_idx_o), 32'd9);
        rst = 1'b1;
        tick(1);
        chk("midrst_line", 32'(pad.CTRL_SDATA_o), 32'd1);
        chk("midrst_busy", 32'(pad.busy_o), 32'd0);
        chk("midrst_idx", 32'(pad.bit_idx_o), 32'd0);
        // Latch already high at reset release is not a rise
        pad.CTRL_LATCH_i = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("latch_at_rel_busy", 32'(pad.busy_o), 32'd0);
        pad.CTRL_LATCH_i = 1'b0;
        tick(10);
        chk("latch_at_rel_idle", 32'(pad.busy_o), 32'd0);
        poll(2'b01, 16'h0002, 16'h0000, 18, "post_rst");

        // Randomized polls, all four mode codes
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            poll(rm, ra, rb, 18, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
